glyph_dma_sched: RTL and testbench

- Per-scanline DMA scheduler for a row of text sprites that share one greeting-message ROM and one font glyph ROM.
- On each request it does two things in a fixed pipelined slot sequence:
  - fetches SPR_CNT code points from the message ROM;
  - issues one font-ROM slot per sprite, with the matching dma_avail strobe.
- Sits between the line-timing logic and the sprite array, and replaces hand-decoded sx-compare DMA slots.

---
 rtl/glyph_dma_sched.sv | 105 ++++++++++
 tb/tb_glyph_dma_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/glyph_dma_sched.sv
// Per-scanline DMA scheduler: fetches one code point per sprite from the message ROM,
// then issues one font-ROM slot per sprite with a one-hot dma_avail strobe.
module glyph_dma_sched #(
    parameter int unsigned SPR_CNT      = 8,
    parameter int unsigned CP_W         = 7,
    parameter int unsigned MSG_ADDRW    = 9,
    parameter int unsigned GREET_LENGTH = 16,
    parameter int unsigned FONT_HEIGHT  = 8,
    parameter int unsigned FONT_GLYPHS  = 64,
    parameter int unsigned CP_START     = 'h20,
    parameter int unsigned FONT_ADDRW   = $clog2(FONT_GLYPHS*FONT_HEIGHT)
) (
    input  logic                                  video_clk_pix,
    input  logic                                  video_rst_n,
    input  logic                                  dma_start,
    input  logic [MSG_ADDRW-1:0]                  msg_start,
    input  logic                                  row_sel,
    output logic [MSG_ADDRW-1:0]                  greet_addr,
    input  logic [CP_W-1:0]                       greet_data,
    output logic [FONT_ADDRW-1:0]                 font_addr,
    input  logic [SPR_CNT*$clog2(FONT_HEIGHT)-1:0] spr_glyph_line,
    output logic [SPR_CNT-1:0]                    spr_dma_avail,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  overrun
);
    localparam int unsigned LINE_W = $clog2(FONT_HEIGHT);
    localparam int unsigned T_W    = $clog2(SPR_CNT + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nx;
    logic [T_W-1:0]       t, t_nx;
    logic [MSG_ADDRW-1:0] base, base_nx;
    logic [CP_W-1:0]      cp [SPR_CNT];

    // Out-of-range code points map to the blank glyph 0, never past the font ROM.
    function automatic logic [FONT_ADDRW-1:0] glyph_addr(input logic [CP_W-1:0] c,
                                                        input logic [LINE_W-1:0] ln);
        int unsigned cv;
        int unsigned g;
        cv = 32'(c);
        g  = (cv >= CP_START && cv < CP_START + FONT_GLYPHS) ? cv - CP_START : 0;
        return FONT_ADDRW'(g * FONT_HEIGHT + 32'(ln));
    endfunction

    always_ff @(posedge video_clk_pix or negedge video_rst_n) begin
        if (!video_rst_n) begin
            state <= IDLE;
            t     <= '0;
            base  <= '0;
            for (int unsigned i = 0; i < SPR_CNT; i++) cp[i] <= '0;
        end else begin
            state <= state_nx;
            t     <= t_nx;
            base  <= base_nx;
            for (int unsigned i = 0; i < SPR_CNT; i++)
                if (state == RUN && t == T_W'(i + 1)) cp[i] <= greet_data;
        end
    end

    always_comb begin
        state_nx = state;
        t_nx     = t;
        base_nx  = base;
        case (state)
            IDLE: if (dma_start) begin
                base_nx  = msg_start + (row_sel ? MSG_ADDRW'(GREET_LENGTH / 2) : '0);
                t_nx     = '0;
                state_nx = RUN;
            end
            RUN: begin
                if (t == T_W'(SPR_CNT + 1)) begin
                    t_nx     = '0;
                    state_nx = DONE;
                end else begin
                    t_nx = t + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        greet_addr    = '0;
        font_addr     = '0;
        spr_dma_avail = '0;
        if (state == RUN) begin
            if (t < T_W'(SPR_CNT)) greet_addr = base + MSG_ADDRW'(t);
            for (int unsigned k = 0; k < SPR_CNT; k++) begin
                if (t == T_W'(k + 2)) begin
                    spr_dma_avail[k] = 1'b1;
                    font_addr = glyph_addr(cp[k], spr_glyph_line[k*LINE_W +: LINE_W]);
                end
            end
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    // Flags a dropped request in the cycle it is presented.
    assign overrun = dma_start & busy;

endmodule

// File: tb/tb_glyph_dma_sched.sv
// Directed bench for glyph_dma_sched: slot sequencing, glyph mapping, overrun and reset abort.
module tb_glyph_dma_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_start;
    logic [8:0]  msg_start;
    logic        row_sel;
    logic [8:0]  greet_addr;
    logic [6:0]  greet_data;
    logic [8:0]  font_addr;
    logic [23:0] gl;
    logic [7:0]  spr_dma_avail;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [6:0]  rom [512];
    logic [8:0]  exp_font [8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) greet_data <= rom[greet_addr];

    glyph_dma_sched #(.SPR_CNT(8), .CP_W(7), .MSG_ADDRW(9), .GREET_LENGTH(16),
                      .FONT_HEIGHT(8), .FONT_GLYPHS(64), .CP_START('h20)) dut (
        .video_clk_pix (clk),
        .video_rst_n   (rst_n),
        .dma_start     (dma_start),
        .msg_start     (msg_start),
        .row_sel       (row_sel),
        .greet_addr    (greet_addr),
        .greet_data    (greet_data),
        .font_addr     (font_addr),
        .spr_glyph_line(gl),
        .spr_dma_avail (spr_dma_avail),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ga"}, 32'(greet_addr), 0);
        chk({tag, "_fa"}, 32'(font_addr), 0);
        chk({tag, "_av"}, 32'(spr_dma_avail), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    task automatic run_req(input logic [8:0] ms, input logic rs, input logic [8:0] eb,
                           input int ovr_t, input bit ovr_done,
                           input int chg_t, input logic [23:0] gl_new);
        dma_start = 1'b1; msg_start = ms; row_sel = rs;
        #1;
        chk("req_busy", 32'(busy), 0);
        chk("req_ovr", 32'(overrun), 0);
        @(posedge clk); #1;
        for (int t = 0; t < 10; t++) begin
            dma_start = (t == ovr_t);
            msg_start = 9'd200; row_sel = 1'b1;
            if (t == chg_t) gl = gl_new;
            #1;
            chk($sformatf("ga_t%0d", t), 32'(greet_addr), (t < 8) ? 32'(9'(eb + 9'(t))) : 0);
            chk($sformatf("av_t%0d", t), 32'(spr_dma_avail), (t >= 2) ? 32'(1) << (t - 2) : 0);
            chk($sformatf("fa_t%0d", t), 32'(font_addr), (t >= 2) ? 32'(exp_font[t-2]) : 0);
            chk($sformatf("busy_t%0d", t), 32'(busy), 1);
            chk($sformatf("done_t%0d", t), 32'(done), 0);
            chk($sformatf("ovr_t%0d", t), 32'(overrun), (t == ovr_t) ? 1 : 0);
            @(posedge clk); #1;
        end
        dma_start = ovr_done;
        #1;
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 1);
        chk("done_av", 32'(spr_dma_avail), 0);
        chk("done_ovr", 32'(overrun), 32'(ovr_done));
        @(posedge clk); #1;
        dma_start = 1'b0;
        #1;
        chk_quiet("post");
        @(posedge clk); #1;
        chk_quiet("post2");
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = 7'h00;
        for (int i = 0; i < 8; i++) rom[i] = 7'(8'h41 + i);
        rom[100] = 7'h1F; rom[101] = 7'h60; rom[102] = 7'h20; rom[103] = 7'h5F;
        rom[104] = 7'h7F; rom[105] = 7'h00; rom[106] = 7'h40; rom[107] = 7'h3A;
        rst_n = 1'b0; dma_start = 1'b0; msg_start = '0; row_sel = 1'b0;
        gl = {8{3'd3}};

        // reset state
        #2;
        chk_quiet("rst");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // basic request, base 0, all lines 3
        exp_font = '{9'd267, 9'd275, 9'd283, 9'd291, 9'd299, 9'd307, 9'd315, 9'd323};
        run_req(9'd0, 1'b0, 9'd0, -1, 1'b0, -1, gl);

        // row_sel offset wraps 504+8 to 0
        run_req(9'd504, 1'b1, 9'd0, -1, 1'b0, -1, gl);

        // out-of-range and edge code points, sprite k uses line k
        gl = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        exp_font = '{9'd0, 9'd1, 9'd2, 9'd507, 9'd4, 9'd5, 9'd262, 9'd215};
        run_req(9'd92, 1'b1, 9'd100, -1, 1'b0, -1, gl);

        // overrun at t=3 and in the DONE cycle
        gl = {8{3'd3}};
        exp_font = '{9'd267, 9'd275, 9'd283, 9'd291, 9'd299, 9'd307, 9'd315, 9'd323};
        run_req(9'd0, 1'b0, 9'd0, 3, 1'b1, -1, gl);

        // sprite 3 line changes 1 -> 6 at t=4
        gl = {8{3'd2}};
        gl[9 +: 3] = 3'd1;
        exp_font = '{9'd266, 9'd274, 9'd282, 9'd294, 9'd298, 9'd306, 9'd314, 9'd322};
        begin
            logic [23:0] g2;
            g2 = gl;
            g2[9 +: 3] = 3'd6;
            run_req(9'd0, 1'b0, 9'd0, -1, 1'b0, 4, g2);
        end

        // reset asserted mid-request at t=5
        gl = {8{3'd3}};
        dma_start = 1'b1; msg_start = 9'd0; row_sel = 1'b0;
        @(posedge clk); #1;
        dma_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_ga", 32'(greet_addr), 5);
        chk("pre_rst_av", 32'(spr_dma_avail), 32'h08);
        rst_n = 1'b0;
        #1;
        chk_quiet("abort");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("abort_done%0d", i), 32'(done), 0);
        end
        chk_quiet("abort_hold");
        rst_n = 1'b1;
        gl = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        exp_font = '{9'd0, 9'd1, 9'd2, 9'd507, 9'd4, 9'd5, 9'd262, 9'd215};
        run_req(9'd92, 1'b1, 9'd100, -1, 1'b0, -1, gl);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
